// File: rtl/camera_qsys_led_seq.sv
// camera_qsys_led_seq: Avalon-MM LED sequencer for the camera Qsys system.
// Software either drives the 10 LEDs directly or loads an 8-entry pattern
// table plus a dwell time. The block then steps through the table on its own,
// looping or one-shot.
// Optional feature: define LED_SEQ_PWM_EN to add BRIGHT-controlled PWM dimming
// through an 8-bit free-running phase counter.
module camera_qsys_led_seq #(
  parameter int DWELL_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  out_port
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t               state, state_nx;
  logic [2:0]           idx, idx_nx;
  logic [DWELL_W-1:0]   cnt, cnt_nx;
  logic                 done_set;

  logic                 ctrl_en, ctrl_loop;
  logic [2:0]           ctrl_last;
  logic [9:0]           direct;
  logic [DWELL_W-1:0]   dwell;
  logic                 done;
  logic [7:0][9:0]      pat;

  logic                 wr;
  logic                 wr_ctrl, wr_direct, wr_dwell, wr_status, wr_pat;
  logic [DWELL_W-1:0]   reload;
  logic [9:0]           disp;

  // Not every writedata bit maps to a register field.
  logic                 unused_wd;
  assign unused_wd = &{1'b0, writedata};

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == 4'd0);
  assign wr_direct = wr && (address == 4'd1);
  assign wr_dwell  = wr && (address == 4'd2);
  assign wr_status = wr && (address == 4'd3);
  assign wr_pat    = wr && address[3];

  // A dwell of 0 behaves as 1, so the reload value for both 0 and 1 is 0.
  assign reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Software-visible register file.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_loop <= 1'b0;
      ctrl_last <= 3'd0;
      direct    <= 10'd0;
      dwell     <= DWELL_W'(1);
      done      <= 1'b0;
      pat       <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= writedata[0];
        ctrl_loop <= writedata[1];
        ctrl_last <= writedata[6:4];
      end
      if (wr_direct) direct <= writedata[9:0];
      if (wr_dwell)  dwell  <= writedata[DWELL_W-1:0];
      if (wr_pat)    pat[address[2:0]] <= writedata[9:0];
      // A step end that finishes a one-shot beats a software clear.
      if (done_set)
        done <= 1'b1;
      else if (wr_status && writedata[8])
        done <= 1'b0;
    end
  end

  // Sequencer state, table index and dwell counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: start/stop from CTRL writes, step advance at counter expiry.
  // Step-end decisions use the LOOP/LAST in force this cycle; a CTRL write
  // landing on the same edge affects the following step.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    done_set = 1'b0;
    if (wr_ctrl && !writedata[0]) begin
      state_nx = IDLE;
      idx_nx   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ctrl) begin
            state_nx = RUN;
            idx_nx   = 3'd0;
            cnt_nx   = reload;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            cnt_nx = reload;
            if (idx >= ctrl_last) begin
              if (ctrl_loop) begin
                idx_nx = 3'd0;
              end else begin
                state_nx = HOLD;
                done_set = 1'b1;
              end
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            cnt_nx = cnt - DWELL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign disp = (state == IDLE) ? direct : pat[idx];

`ifdef LED_SEQ_PWM_EN
  logic [7:0] bright;
  logic [7:0] phase;
  logic       gate;

  assign gate = (bright == 8'hFF) | (phase < bright);

  // Brightness register and free-running PWM phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bright <= 8'hFF;
      phase  <= 8'd0;
    end else begin
      if (wr && (address == 4'd4)) bright <= writedata[7:0];
      phase <= phase + 8'd1;
    end
  end

  // Registered LED drive, gated by the PWM phase.
  always_ff @(posedge clk) begin
    if (!reset_n) out_port <= 10'd0;
    else          out_port <= disp & {10{gate}};
  end
`else
  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (!reset_n) out_port <= 10'd0;
    else          out_port <= disp;
  end
`endif

  // Zero-latency read mux; unmapped addresses and unused bits read 0.
  always_comb begin
    readdata = '0;
    if (address[3]) begin
      readdata[9:0] = pat[address[2:0]];
    end else begin
      case (address[2:0])
        3'd0: begin
          readdata[0]   = ctrl_en;
          readdata[1]   = ctrl_loop;
          readdata[6:4] = ctrl_last;
        end
        3'd1: readdata[9:0] = direct;
        3'd2: readdata[DWELL_W-1:0] = dwell;
        3'd3: begin
          readdata[0]   = (state == RUN);
          readdata[6:4] = idx;
          readdata[8]   = done;
        end
`ifdef LED_SEQ_PWM_EN
        3'd4: readdata[7:0] = bright;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_qsys_led_seq.sv
// Self-checking bench for camera_qsys_led_seq: expected LED values are queued
// as stimulus is applied and compared one per cycle against out_port.
module tb_camera_qsys_led_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  always #5 clk = ~clk;

  camera_qsys_led_seq #(.DWELL_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  typedef struct { string tag; logic [9:0] val; } sb_t;
  sb_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

`ifdef LED_SEQ_PWM_EN
  localparam logic [31:0] BRIGHT_RST = 32'd255;
`else
  localparam logic [31:0] BRIGHT_RST = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [9:0] v, input int n);
    sb_t e;
    e.tag = tag;
    e.val = v;
    repeat (n) sb_q.push_back(e);
  endtask

  // One Avalon write; returns at the falling edge after the write edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // Scoreboard consumer: one expected LED value per cycle, sampled after the edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk(e.tag, 32'(out_port), 32'(e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int on;
    logic [9:0] pv [8];
    pv[0] = 10'h001; pv[1] = 10'h002; pv[2] = 10'h004; pv[3] = 10'h008;
    pv[4] = 10'h010; pv[5] = 10'h020; pv[6] = 10'h040; pv[7] = 10'h080;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_out", 32'(out_port), 0);
    rd("rst_ctrl", 4'd0, 0);
    rd("rst_direct", 4'd1, 0);
    rd("rst_dwell", 4'd2, 1);
    rd("rst_status", 4'd3, 0);
    rd("rst_bright", 4'd4, BRIGHT_RST);
    rd("rst_pat0", 4'd8, 0);

    // Direct drive, 2-edge latency
    wr(4'd1, 32'h2A5);
    chk("dir_pre", 32'(out_port), 0);
    push("dir", 10'h2A5, 3);
    drain();
    rd("dir_rd", 4'd1, 32'h2A5);
    rd("dir_status", 4'd3, 0);

    // Looping sequence, LAST=2, DWELL=3
    for (int k = 0; k < 3; k++) wr(4'(8 + k), 32'(pv[k]));
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h23);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) push("loop", pv[k], 3);
    rd("loop_st0", 4'd3, 32'h01);
    repeat (3) @(negedge clk);
    rd("loop_st1", 4'd3, 32'h11);
    repeat (3) @(negedge clk);
    rd("loop_st2", 4'd3, 32'h21);
    drain();

    // Stop, then one-shot
    wr(4'd0, 32'h00);
    push("stop", 10'h2A5, 2);
    drain();
    wr(4'd0, 32'h21);
    for (int k = 0; k < 3; k++) push("oneshot", pv[k], 3);
    push("hold", pv[2], 4);
    drain();
    rd("hold_status", 4'd3, 32'h120);
    wr(4'd3, 32'h100);
    rd("done_clr", 4'd3, 32'h020);
    wr(4'd0, 32'h00);
    push("back_direct", 10'h2A5, 2);
    drain();
    rd("idle_status", 4'd3, 0);

    // DWELL=0 behaves as 1; LAST raised mid-run
    for (int k = 3; k < 8; k++) wr(4'(8 + k), 32'(pv[k]));
    wr(4'd2, 32'd0);
    rd("dwell0_rd", 4'd2, 0);
    wr(4'd0, 32'h03);
    push("last0", pv[0], 4);
    drain();
    wr(4'd0, 32'h73);
    for (int k = 0; k < 10; k++) push("last7_wrap", pv[k % 8], 1);
    drain();

    // Reset mid-run
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rstm_out", 32'(out_port), 0);
    rd("rstm_status", 4'd3, 0);
    rd("rstm_dwell", 4'd2, 1);
    rd("rstm_bright", 4'd4, BRIGHT_RST);
    rd("rstm_ctrl", 4'd0, 0);

    // Unmapped address ignored
    wr(4'd5, 32'hFFFF_FFFF);
    rd("unmapped", 4'd5, 0);

`ifdef LED_SEQ_PWM_EN
    wr(4'd4, 32'd64);
    wr(4'd1, 32'h3FF);
    rd("bright_rd", 4'd4, 32'd64);
    repeat (2) @(negedge clk);
    on = 0;
    repeat (256) begin
      @(negedge clk);
      if (out_port == 10'h3FF) on++;
    end
    chk("pwm64_duty", on, 64);
    wr(4'd4, 32'd0);
    repeat (2) @(negedge clk);
    on = 0;
    repeat (256) begin
      @(negedge clk);
      if (out_port != 10'h000) on++;
    end
    chk("pwm0_off", on, 0);
`else
    wr(4'd4, 32'd64);
    rd("bright_ignored", 4'd4, 0);
    wr(4'd1, 32'h3FF);
    push("full_on", 10'h3FF, 4);
    drain();
    on = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_port != 10'h3FF) on++;
    end
    chk("no_pwm_steady", on, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
